softmax_row_ctrl: RTL and testbench

//  Core-side (responder) end of the serial softmax row interface: accepts a Start pulse plus N+1 FP32

---
 rtl/softmax_row_ctrl_if.sv | 11 +
 rtl/softmax_row_ctrl.sv | 110 +++++++++++
 tb/tb_softmax_row_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/softmax_row_ctrl_if.sv
// softmax_row_ctrl_if: request/ack port to the shared FP32 unit
interface softmax_row_ctrl_if #(parameter int W = 32);
  logic req;
  logic ack;
  logic [1:0] op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] res;
  modport master(output req, op, a, b, input ack, res);
  modport slave(input req, op, a, b, output ack, res);
endinterface

// File: rtl/softmax_row_ctrl.sv
// softmax_row_ctrl: sequences exp/add/div ops on a shared FPU to compute a softmax row of up to 4 elements
module softmax_row_ctrl #(parameter int W = 32) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] datain,
  input  logic [2:0]   n,
  output logic [W-1:0] y0,
  output logic [W-1:0] y1,
  output logic [W-1:0] y2,
  output logic [W-1:0] y3,
  output logic         done,
  softmax_row_ctrl_if.master fpu
);
  typedef enum logic [2:0] {IDLE, LOAD, EXP, SUM, DIV, FIN} state_t;
  state_t state, state_n;
  logic [1:0] row_n, idx;
  logic [W-1:0] x [4];
  logic [W-1:0] e [4];
  logic [W-1:0] r [4];
  logic [W-1:0] y [4];
  logic [W-1:0] sum;
  logic last;
  assign last = idx == row_n;
  assign y0 = y[0];
  assign y1 = y[1];
  assign y2 = y[2];
  assign y3 = y[3];
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  // next state and FPU request; operands come straight from registers that only move on ack, so they hold during stalls
  always_comb begin
    state_n = state;
    fpu.req = 1'b0;
    fpu.op = 2'd0;
    fpu.a = '0;
    fpu.b = '0;
    case (state)
      IDLE: state_n = start ? LOAD : IDLE;
      LOAD: state_n = last ? EXP : LOAD;
      EXP: begin
        fpu.req = 1'b1;
        fpu.a = x[idx];
        if (fpu.ack && last) state_n = row_n == 2'd0 ? DIV : SUM;
      end
      SUM: begin
        fpu.req = 1'b1;
        fpu.op = 2'd1;
        fpu.a = sum;
        fpu.b = e[idx];
        if (fpu.ack && last) state_n = DIV;
      end
      DIV: begin
        fpu.req = 1'b1;
        fpu.op = 2'd2;
        fpu.a = e[idx];
        fpu.b = sum;
        if (fpu.ack && last) state_n = FIN;
      end
      FIN: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // datapath: operand capture, op results, and result publish on the final divide ack
  always_ff @(posedge clk) begin
    if (rst) begin
      row_n <= '0;
      idx <= '0;
      sum <= '0;
      done <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        x[i] <= '0;
        e[i] <= '0;
        r[i] <= '0;
        y[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          row_n <= n > 3'd3 ? 2'd3 : n[1:0];
          idx <= '0;
        end
        LOAD: begin
          x[idx] <= datain;
          idx <= last ? 2'd0 : idx + 2'd1;
        end
        EXP: if (fpu.ack) begin
          e[idx] <= fpu.res;
          if (last) begin
            sum <= idx == 2'd0 ? fpu.res : e[0];
            idx <= row_n == 2'd0 ? 2'd0 : 2'd1;
          end else idx <= idx + 2'd1;
        end
        SUM: if (fpu.ack) begin
          sum <= fpu.res;
          idx <= last ? 2'd0 : idx + 2'd1;
        end
        DIV: if (fpu.ack) begin
          r[idx] <= fpu.res;
          if (last) begin
            done <= 1'b1;
            for (int k = 0; k < 4; k++) y[k] <= 2'(k) > row_n ? '0 : 2'(k) == idx ? fpu.res : r[k];
          end else idx <= idx + 2'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_softmax_row_ctrl.sv
// tb_softmax_row_ctrl: randomized scoreboard bench with a behavioural FPU and softmax reference
module tb_softmax_row_ctrl;
  logic clk = 0, rst = 1, start = 0;
  logic [31:0] datain = 0;
  logic [2:0] n = 0;
  logic [31:0] y0, y1, y2, y3;
  logic done;
  softmax_row_ctrl_if #(.W(32)) fpu();
  softmax_row_ctrl #(.W(32)) dut(.clk(clk), .rst(rst), .start(start), .datain(datain), .n(n),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3), .done(done), .fpu(fpu));
  typedef struct { logic [3:0][31:0] y; int c0; int lat; } exp_t;
  exp_t sb[$];
  exp_t got;
  int checks = 0, passes = 0, cyc = 0, dones = 0, stall_max = 0;
  int ops[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [31:0] r2f(real v);
    logic [63:0] d;
    logic [23:0] m;
    int ex;
    if (v == 0.0) return 32'h0;
    d = $realtobits(v);
    ex = int'(d[62:52]) - 896;
    m = {1'b0, d[51:29]} + 24'(d[28]);
    if (m[23]) begin
      ex++;
      m = '0;
    end
    return {d[63], 8'(ex), m[22:0]};
  endfunction
  function automatic real f2r(logic [31:0] f);
    if (f[30:0] == 0) return 0.0;
    return $bitstoreal({f[31], 11'(int'(f[30:23]) + 896), f[22:0], 29'b0});
  endfunction
  function automatic logic [31:0] fmodel(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    if (op == 2'd0) return r2f($exp(f2r(a)));
    if (op == 2'd1) return r2f(f2r(a) + f2r(b));
    return r2f(f2r(a) / f2r(b));
  endfunction
  task automatic check(input string nm, input longint act, input longint req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, req);
  endtask
  task automatic check_y(input string nm, input logic [31:0] act, input logic [31:0] req);
    longint d;
    d = longint'(act) - longint'(req);
    if (d < 0) d = -d;
    checks++;
    if (d <= (req == 0 ? 0 : 4)) passes++;
    else $display("FAIL %s: got %08h expected %08h", nm, act, req);
  endtask
  // behavioural FPU: random stall, then ack with the result; also checks operands hold during a stall
  initial begin
    bit pend;
    int cnt, target;
    logic [65:0] held;
    pend = 0;
    cnt = 0;
    target = 0;
    held = '0;
    fpu.ack = 0;
    fpu.res = 0;
    forever begin
      @(negedge clk);
      if (rst || !fpu.req) begin
        fpu.ack = 0;
        pend = 0;
      end else begin
        if (!pend) begin
          pend = 1;
          cnt = 0;
          target = $urandom_range(0, stall_max);
          held = {fpu.op, fpu.a, fpu.b};
        end else check("op_stable", longint'({fpu.op, fpu.a, fpu.b} == held), 1);
        if (cnt == target) begin
          fpu.ack = 1;
          fpu.res = fmodel(fpu.op, fpu.a, fpu.b);
          ops.push_back(int'(fpu.op));
          pend = 0;
        end else begin
          fpu.ack = 0;
          cnt++;
        end
      end
    end
  end
  // monitor: every Done pops the oldest expected row
  always @(negedge clk) if (!rst && done) begin
    dones++;
    if (sb.size() == 0) check("unexpected_done", 1, 0);
    else begin
      got = sb.pop_front();
      check_y("y0", y0, got.y[0]);
      check_y("y1", y1, got.y[1]);
      check_y("y2", y2, got.y[2]);
      check_y("y3", y3, got.y[3]);
      if (got.lat >= 0) check("latency", cyc - got.c0, got.lat);
    end
  end
  task automatic run_row(input logic [2:0] nv, input logic [3:0][31:0] xs, input bit restart);
    exp_t ent;
    real es [4];
    real s;
    int m, d0;
    m = nv > 3 ? 3 : int'(nv);
    s = 0.0;
    for (int i = 0; i <= m; i++) begin
      es[i] = $exp(f2r(xs[i]));
      s += es[i];
    end
    for (int k = 0; k < 4; k++) ent.y[k] = k <= m ? r2f(es[k] / s) : 32'h0;
    ent.lat = stall_max == 0 ? 4 * m + 4 : -1;
    ops.delete();
    d0 = dones;
    @(negedge clk);
    start = 1;
    n = nv;
    datain = $urandom;
    ent.c0 = cyc;
    sb.push_back(ent);
    for (int i = 0; i <= m; i++) begin
      @(negedge clk);
      start = 0;
      datain = xs[i];
    end
    @(negedge clk);
    datain = $urandom;
    if (restart) begin
      for (int k = 0; k < 50 && !(fpu.req && fpu.op == 2'd0); k++) @(negedge clk);
      start = 1;
      n = 3'd0;
      @(negedge clk);
      start = 0;
    end
    for (int k = 0; k < 300 && dones == d0; k++) @(negedge clk);
    repeat (4) @(negedge clk);
    check("one_done", dones - d0, 1);
    check("op_count", ops.size(), 3 * m + 2);
    sb.delete();
  endtask
  initial begin
    logic [3:0][31:0] xs, x1234;
    int exp_ops [11] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 2, 2};
    longint sa, se;
    int d0;
    x1234 = {r2f(4.0), r2f(3.0), r2f(2.0), r2f(1.0)};
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("rst_done", done, 0);
    check("rst_req", fpu.req, 0);
    check("rst_a", fpu.a, 0);
    check("rst_y0", y0, 0);
    check("rst_y3", y3, 0);
    stall_max = 0;
    run_row(3'd3, '0, 0);
    sa = 0;
    se = 0;
    for (int i = 0; i < 11; i++) begin
      sa = sa * 4 + (i < ops.size() ? ops[i] : 3);
      se = se * 4 + exp_ops[i];
    end
    check("op_seq", sa, se);
    check("t1_y2", y2, 32'h3E800000);
    stall_max = 5;
    run_row(3'd3, '0, 0);
    check("t2_y0", y0, 32'h3E800000);
    stall_max = 0;
    run_row(3'd0, {96'h0, 32'h40000000}, 0);
    check("t3_y0", y0, 32'h3F800000);
    check("t3_y1", y1, 0);
    run_row(3'd7, '0, 1);
    check("t4_y3", y3, 32'h3E800000);
    stall_max = 2;
    ops.delete();
    @(negedge clk);
    start = 1;
    n = 3'd3;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 4; i++) begin
      datain = x1234[i];
      @(negedge clk);
    end
    for (int k = 0; k < 100 && !(fpu.req && fpu.op == 2'd1); k++) @(negedge clk);
    d0 = dones;
    rst = 1;
    @(negedge clk);
    check("t5_req", fpu.req, 0);
    check("t5_y0", y0, 0);
    check("t5_done", done, 0);
    rst = 0;
    repeat (30) @(negedge clk);
    check("t5_no_done", dones - d0, 0);
    run_row(3'd3, x1234, 0);
    for (int r = 0; r < 4; r++) begin
      stall_max = r;
      run_row(3'd3, x1234, 0);
    end
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 4; i++) xs[i] = r2f(real'(int'($urandom_range(0, 32)) - 16) * 0.25);
      stall_max = $urandom_range(0, 2);
      run_row(3'($urandom_range(0, 7)), xs, r % 4 == 3);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
